// File: rtl/hazard_pkg.sv
// Shared hazard-control definitions: flush FSM encoding, counter-width helper
// and the default slot/register widths used by the decoder and forwarding unit.
package hazard_pkg;

  localparam int unsigned ISSUE_W_DEFAULT = 2;
  localparam int unsigned REG_W_DEFAULT   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  // Ceiling log2, minimum 1 so a counter is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard bundle: decode slots, EX load/branch info and hazard outputs.
interface hazard_scoreboard_unit_if
  import hazard_pkg::*;
#(
  parameter int unsigned ISSUE_W = ISSUE_W_DEFAULT,
  parameter int unsigned REG_W   = REG_W_DEFAULT
);
  logic [ISSUE_W-1:0]       id_valid;
  logic [ISSUE_W*REG_W-1:0] id_rs;
  logic [ISSUE_W*REG_W-1:0] id_rt;
  logic [ISSUE_W*REG_W-1:0] id_rd;
  logic [ISSUE_W-1:0]       id_we;
  logic                     ex_load_valid;
  logic [REG_W-1:0]         ex_load_rd;
  logic                     br_valid;
  logic                     prediction;
  logic                     actual_taken;
  logic                     pc_src;
  logic [ISSUE_W-1:0]       issue_mask;
  logic                     stall;
  logic                     flush;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_we, ex_load_valid, ex_load_rd,
    output br_valid, prediction, actual_taken, pc_src,
    input  issue_mask, stall, flush
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_we, ex_load_valid, ex_load_rd,
    input  br_valid, prediction, actual_taken, pc_src,
    output issue_mask, stall, flush
  );
endinterface

// File: rtl/hazard_reg_scoreboard.sv
// Per-register load countdown scoreboard with NUM_RD combinational busy lookups.
module hazard_reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = REG_W_DEFAULT,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned NUM_RD   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_valid,
  input  logic [REG_W-1:0]        set_rd,
  input  logic [NUM_RD*REG_W-1:0] rd_idx,
  output logic [NUM_RD-1:0]       busy
);
  localparam int unsigned NumRegs = 1 << REG_W;
  localparam int unsigned CntW    = clog2(LOAD_LAT + 1);

  logic [CntW-1:0] cnt_q [NumRegs];
  logic [CntW-1:0] cnt_d [NumRegs];

  // Load set wins over the countdown; r0 is never marked.
  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < NumRegs; r++) begin
      if (set_valid && (set_rd == REG_W'(r))) begin
        cnt_d[r] = CntW'(LOAD_LAT);
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Busy includes a load arriving in EX this very cycle.
  always_comb begin
    busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [REG_W-1:0] idx;
      idx = rd_idx[p*REG_W +: REG_W];
      busy[p] = (idx != '0) && ((cnt_q[idx] != '0) || (set_valid && (set_rd == idx)));
    end
  end
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard and flush controller: load-use and intra-bundle RAW issue gating plus
// a multi-cycle redirect flush. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned ISSUE_W      = ISSUE_W_DEFAULT,
  parameter int unsigned REG_W        = REG_W_DEFAULT,
  parameter int unsigned LOAD_LAT     = 2,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_flush_events,
`endif
  hazard_scoreboard_unit_if.slave  bus
);
  logic [2*ISSUE_W*REG_W-1:0] rd_idx;
  logic [2*ISSUE_W-1:0]       busy;
  logic [ISSUE_W-1:0]         issue_raw;
  logic                       stall_raw;
  logic                       trigger;
  logic                       flush_raw;
  flush_state_e               state_q, state_d;
  logic [2:0]                 rem_q, rem_d;

  // Slot k sources occupy read ports 2k (rs) and 2k+1 (rt).
  always_comb begin
    rd_idx = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      rd_idx[(2*k)*REG_W +: REG_W]   = bus.id_rs[k*REG_W +: REG_W];
      rd_idx[(2*k+1)*REG_W +: REG_W] = bus.id_rt[k*REG_W +: REG_W];
    end
  end

  hazard_reg_scoreboard #(
    .REG_W    (REG_W),
    .LOAD_LAT (LOAD_LAT),
    .NUM_RD   (2 * ISSUE_W)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (bus.ex_load_valid),
    .set_rd    (bus.ex_load_rd),
    .rd_idx    (rd_idx),
    .busy      (busy)
  );

  // In-order issue: any valid slot that cannot go blocks every younger slot.
  always_comb begin
    logic older_ok;
    logic blocked;
    issue_raw = '0;
    stall_raw = 1'b0;
    older_ok  = 1'b1;
    for (int k = 0; k < ISSUE_W; k++) begin
      blocked = busy[2*k] || busy[2*k+1];
      for (int j = 0; j < k; j++) begin
        if (bus.id_valid[j] && bus.id_we[j] && (bus.id_rd[j*REG_W +: REG_W] != '0) &&
            ((bus.id_rd[j*REG_W +: REG_W] == bus.id_rs[k*REG_W +: REG_W]) ||
             (bus.id_rd[j*REG_W +: REG_W] == bus.id_rt[k*REG_W +: REG_W]))) begin
          blocked = 1'b1;
        end
      end
      issue_raw[k] = bus.id_valid[k] && !blocked && older_ok;
      if (bus.id_valid[k] && !issue_raw[k]) begin
        older_ok  = 1'b0;
        stall_raw = 1'b1;
      end
    end
  end

  assign trigger = (bus.br_valid && (bus.prediction != bus.actual_taken)) || bus.pc_src;

  // Flush FSM next state; a trigger in FLUSH restarts the hold window.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    flush_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          flush_raw = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            rem_d   = 3'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        flush_raw = 1'b1;
        if (trigger) begin
          rem_d = 3'(FLUSH_CYCLES - 1);
        end else if (rem_q <= 3'd1) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Flush FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Flush overrides stall so the redirect always proceeds; all outputs low in reset.
  always_comb begin
    bus.flush      = rst_n && flush_raw;
    bus.stall      = rst_n && stall_raw && !flush_raw;
    bus.issue_mask = (rst_n && !flush_raw) ? issue_raw : '0;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (bus.stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (trigger && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_events = perf_flush_q;
`endif
endmodule
